// File: rtl/mac_crc32_stream_if.sv
// Stream interface of the Ethernet CRC-32 engine: the beat handshake with
// framing and keep, plus the per-frame result and error outputs.
interface mac_crc32_stream_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    localparam int NB = DATA_W / 8;

    logic              valid_i;
    logic              ready_o;
    logic              sof_i;
    logic              eop_i;
    logic              abort_i;
    logic [DATA_W-1:0] data_i;
    logic [NB-1:0]     keep_i;
    logic [31:0]       crc_o;
    logic              crc_valid_o;
    logic              crc_ok_o;
    logic [CNT_W-1:0]  byte_cnt_o;
    logic              err_o;

    // Producer side: drives beats, observes the handshake and the results.
    modport master (
        output valid_i, sof_i, eop_i, abort_i, data_i, keep_i,
        input  ready_o, crc_o, crc_valid_o, crc_ok_o, byte_cnt_o, err_o
    );

    // CRC engine side.
    modport slave (
        input  valid_i, sof_i, eop_i, abort_i, data_i, keep_i,
        output ready_o, crc_o, crc_valid_o, crc_ok_o, byte_cnt_o, err_o
    );
endinterface

// File: rtl/mac_crc32_stream.sv
// Ethernet CRC-32 engine for TX FCS generation and RX FCS checking.
// Consumes DATA_W-bit beats framed by sof/eop, applies all bytes of a beat in
// one cycle, and reports the complemented FCS, a residue-based good flag and
// a saturating byte count one cycle after the eop beat is accepted.
module mac_crc32_stream #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    mac_crc32_stream_if.slave s
);
    localparam int          NB      = DATA_W / 8;
    localparam int          LEN_W   = $clog2(NB + 1);
    localparam logic [31:0] POLY    = 32'hEDB8_8320;
    localparam logic [31:0] INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] RESIDUE = 32'hDEBB_20E3;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      crc_q, crc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      fcs_q, fcs_d;
    logic             ok_q, ok_d;
    logic [CNT_W-1:0] cnt_out_q, cnt_out_d;
    logic             err_q, err_d;

    logic [NB-1:0]    keep_mask;
    logic [LEN_W-1:0] keep_len;
    logic             keep_bad;
    logic [NB-1:0]    use_mask;
    logic [LEN_W-1:0] beat_len;
    logic             ready;
    logic             accept;
    logic             restart;
    logic [31:0]      crc_base;
    logic [31:0]      crc_next;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] cnt_next;

    // One reflected-CRC byte step: the byte enters at the LSB end.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
        end
        return r;
    endfunction

    // Whole beat, bytes in wire order 0..NB-1, skipping bytes not in use_m.
    function automatic logic [31:0] crc_beat(input logic [31:0] c,
                                             input logic [DATA_W-1:0] d,
                                             input logic [NB-1:0] use_m);
        logic [31:0] r;
        r = c;
        for (int k = 0; k < NB; k++) begin
            if (use_m[k]) begin
                r = crc_byte(r, d[8*k +: 8]);
            end
        end
        return r;
    endfunction

    // Counter add that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] base,
                                                  input logic [LEN_W-1:0] len);
        logic [CNT_W:0] sum;
        sum = {1'b0, base} + (CNT_W + 1)'(len);
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    // Keep decode: usable bytes are the run of ones starting at bit 0;
    // an empty run or any set bit above the run is a protocol error.
    always_comb begin
        logic run;
        // NOTE: every signal gets a default before any branch, so no path can
        // leave it unassigned and infer a latch.
        keep_mask = '0;
        keep_len  = '0;
        run       = 1'b1;
        for (int k = 0; k < NB; k++) begin
            if (run && s.keep_i[k]) begin
                keep_mask[k] = 1'b1;
                keep_len     = keep_len + LEN_W'(1);
            end else begin
                run = 1'b0;
            end
        end
        keep_bad = (keep_mask == '0) || (keep_mask != s.keep_i);
    end

    // Datapath shared by every accepted beat: a new frame starts from INIT
    // and a zero count; otherwise the beat continues the running state.
    always_comb begin
        ready    = (state_q != DONE);
        accept   = s.valid_i && ready && !s.abort_i;
        restart  = (state_q == IDLE) || s.sof_i;
        use_mask = s.eop_i ? keep_mask : {NB{1'b1}};
        beat_len = s.eop_i ? keep_len : LEN_W'(NB);
        crc_base = restart ? INIT : crc_q;
        cnt_base = restart ? '0 : cnt_q;
        crc_next = crc_beat(crc_base, s.data_i, use_mask);
        cnt_next = sat_add(cnt_base, beat_len);
    end

    // Framing FSM: next state, running CRC/count, and result capture on eop.
    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        cnt_d     = cnt_q;
        fcs_d     = fcs_q;
        ok_d      = ok_q;
        cnt_out_d = cnt_out_q;
        err_d     = 1'b0;
        case (state_q)
            IDLE, ACC: begin
                if (s.abort_i) begin
                    // Abort wins over any beat presented in the same cycle.
                    state_d = IDLE;
                    crc_d   = INIT;
                    cnt_d   = '0;
                end else if (accept) begin
                    if ((state_q == IDLE) && !s.sof_i) begin
                        // Stray beat outside a frame: dropped.
                        err_d = 1'b1;
                    end else begin
                        crc_d = crc_next;
                        cnt_d = cnt_next;
                        err_d = ((state_q == ACC) && s.sof_i) || (s.eop_i && keep_bad);
                        if (s.eop_i) begin
                            state_d   = DONE;
                            fcs_d     = ~crc_next;
                            ok_d      = (crc_next == RESIDUE);
                            cnt_out_d = cnt_next;
                        end else begin
                            state_d = ACC;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                crc_d   = INIT;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                crc_d   = INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q   <= IDLE;
            crc_q     <= INIT;
            cnt_q     <= '0;
            fcs_q     <= '0;
            ok_q      <= 1'b0;
            cnt_out_q <= '0;
            err_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q   <= state_d;
            crc_q     <= crc_d;
            cnt_q     <= cnt_d;
            fcs_q     <= fcs_d;
            ok_q      <= ok_d;
            cnt_out_q <= cnt_out_d;
            err_q     <= err_d;
        end
    end

    assign s.ready_o     = ready;
    assign s.crc_valid_o = (state_q == DONE);
    assign s.crc_o       = fcs_q;
    assign s.crc_ok_o    = ok_q;
    assign s.byte_cnt_o  = cnt_out_q;
    assign s.err_o       = err_q;
endmodule

// File: tb/tb_mac_crc32_stream.sv
// Bench for mac_crc32_stream: three instances (8/32/64-bit beats) share one
// driver selected by sel. Known-answer vectors, hand-written protocol corner
// cases, and random frames checked against a table-driven byte-serial model.
module tb_mac_crc32_stream;
    typedef logic [7:0] bq_t[$];

    typedef struct {
        logic [4:0][31:0] d;
        int               nbeats;
        logic [3:0]       last_keep;
        logic [31:0]      exp_crc;
        bit               chk_crc;
        int               exp_cnt;
        bit               exp_ok;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    int          sel;
    logic        tb_valid, tb_sof, tb_eop, tb_abort;
    logic [63:0] tb_data;
    logic [7:0]  tb_keep;

    logic        mon_ready, mon_valid, mon_ok, mon_err;
    logic [31:0] mon_crc;
    logic [15:0] mon_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0;
    int n_err    = 0;

    logic [31:0] crc_tab[256];

    mac_crc32_stream_if #(.DATA_W(8),  .CNT_W(6))  if8 ();
    mac_crc32_stream_if #(.DATA_W(32), .CNT_W(16)) if32 ();
    mac_crc32_stream_if #(.DATA_W(64), .CNT_W(16)) if64 ();

    assign if8.valid_i  = tb_valid && (sel == 0);
    assign if8.sof_i    = tb_sof;
    assign if8.eop_i    = tb_eop;
    assign if8.abort_i  = tb_abort && (sel == 0);
    assign if8.data_i   = tb_data[7:0];
    assign if8.keep_i   = tb_keep[0:0];
    assign if32.valid_i = tb_valid && (sel == 1);
    assign if32.sof_i   = tb_sof;
    assign if32.eop_i   = tb_eop;
    assign if32.abort_i = tb_abort && (sel == 1);
    assign if32.data_i  = tb_data[31:0];
    assign if32.keep_i  = tb_keep[3:0];
    assign if64.valid_i = tb_valid && (sel == 2);
    assign if64.sof_i   = tb_sof;
    assign if64.eop_i   = tb_eop;
    assign if64.abort_i = tb_abort && (sel == 2);
    assign if64.data_i  = tb_data;
    assign if64.keep_i  = tb_keep;

    mac_crc32_stream #(.DATA_W(8),  .CNT_W(6))  u_dut8  (.clk_i(clk), .reset_i(rst_n), .s(if8));
    mac_crc32_stream #(.DATA_W(32), .CNT_W(16)) u_dut32 (.clk_i(clk), .reset_i(rst_n), .s(if32));
    mac_crc32_stream #(.DATA_W(64), .CNT_W(16)) u_dut64 (.clk_i(clk), .reset_i(rst_n), .s(if64));

    always_comb begin
        case (sel)
            0: begin
                mon_ready = if8.ready_o;  mon_valid = if8.crc_valid_o; mon_ok = if8.crc_ok_o;
                mon_err   = if8.err_o;    mon_crc   = if8.crc_o;       mon_cnt = 16'(if8.byte_cnt_o);
            end
            1: begin
                mon_ready = if32.ready_o; mon_valid = if32.crc_valid_o; mon_ok = if32.crc_ok_o;
                mon_err   = if32.err_o;   mon_crc   = if32.crc_o;       mon_cnt = if32.byte_cnt_o;
            end
            default: begin
                mon_ready = if64.ready_o; mon_valid = if64.crc_valid_o; mon_ok = if64.crc_ok_o;
                mon_err   = if64.err_o;   mon_crc   = if64.crc_o;       mon_cnt = if64.byte_cnt_o;
            end
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (sel=%0d): got %0h, expected %0h", name, sel, act, exp);
        end
    endtask

    // Reference: classic 256-entry table, one byte per lookup.
    function automatic logic [31:0] ref_crc(input bq_t q);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (q[i]) c = crc_tab[c[7:0] ^ q[i]] ^ (c >> 8);
        return ~c;
    endfunction

    function automatic bq_t rand_bytes(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
        return q;
    endfunction

    function automatic bq_t str_bytes(input string str);
        bq_t q;
        for (int i = 0; i < str.len(); i++) q.push_back(str[i]);
        return q;
    endfunction

    // Advance to the next falling edge and tally output pulses seen there.
    task automatic step();
        @(negedge clk);
        if (mon_valid) n_valid++;
        if (mon_err)   n_err++;
    endtask

    // Present one beat, hold it while ready is low (bounded), let it be taken.
    task automatic beat(input logic sof, input logic eop, input logic [63:0] d,
                        input logic [7:0] k, output int waits);
        tb_valid = 1'b1; tb_sof = sof; tb_eop = eop; tb_data = d; tb_keep = k;
        waits = 0;
        while (!mon_ready && waits < 4) begin
            step();
            waits++;
        end
        if (!mon_ready) check("ready_timeout", {63'd0, mon_ready}, 64'd1);
        step();
        tb_valid = 1'b0; tb_sof = 1'b0; tb_eop = 1'b0;
    endtask

    // Send a whole frame split into nb-byte beats, then check the DONE cycle.
    task automatic send_frame(input bq_t q, input int nb, input int exp_wait, input int max_cnt);
        int          pre, w, take, exp_cnt;
        logic [63:0] d;
        logic [7:0]  k;
        logic [31:0] exp_crc;
        bit          last;
        pre     = n_valid;
        exp_crc = ref_crc(q);
        exp_cnt = (q.size() > max_cnt) ? max_cnt : q.size();
        for (int i = 0; i < q.size(); i += nb) begin
            take = (q.size() - i < nb) ? q.size() - i : nb;
            last = (i + nb >= q.size());
            d    = {$urandom(), $urandom()};
            for (int j = 0; j < take; j++) d[8*j +: 8] = q[i+j];
            k = last ? 8'((1 << take) - 1) : 8'hFF;
            beat(i == 0, last, d, k, w);
            check("beat_stall", 64'(w), 64'((i == 0) ? exp_wait : 0));
            if (!last) check("no_early_valid", 64'(n_valid), 64'(pre));
        end
        check("valid_pulse", {63'd0, mon_valid}, 64'd1);
        check("valid_count", 64'(n_valid), 64'(pre + 1));
        check("ready_low_in_done", {63'd0, mon_ready}, 64'd0);
        check("crc", 64'(mon_crc), 64'(exp_crc));
        check("byte_cnt", 64'(mon_cnt), 64'(exp_cnt));
        check("crc_ok", {63'd0, mon_ok}, {63'd0, exp_crc == 32'h2144_DF1C});
        check("no_err", {63'd0, mon_err}, 64'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        vec_t        vecs[4];
        bq_t         q;
        int          w, pre_v, pre_e, nb, len;
        logic [31:0] fcs, held;

        for (int i = 0; i < 256; i++) begin
            logic [31:0] c;
            c = 32'(i);
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            crc_tab[i] = c;
        end

        vecs[0] = '{d: {32'h0, 32'h0, 32'h0000_0039, 32'h3837_3635, 32'h3433_3231}, nbeats: 3,
                    last_keep: 4'b0001, exp_crc: 32'hCBF4_3926, chk_crc: 1'b1, exp_cnt: 9, exp_ok: 1'b0};
        vecs[1] = '{d: {32'h0, 32'h0000_00CB, 32'hF439_2639, 32'h3837_3635, 32'h3433_3231}, nbeats: 4,
                    last_keep: 4'b0001, exp_crc: 32'h2144_DF1C, chk_crc: 1'b1, exp_cnt: 13, exp_ok: 1'b1};
        vecs[2] = '{d: {32'h0, 32'h0000_00CB, 32'hF439_2639, 32'h3837_3635, 32'h3433_3230}, nbeats: 4,
                    last_keep: 4'b0001, exp_crc: 32'h0, chk_crc: 1'b0, exp_cnt: 13, exp_ok: 1'b0};
        vecs[3] = '{d: {32'h0, 32'h0, 32'h0, 32'h0, 32'h3433_3231}, nbeats: 1,
                    last_keep: 4'b1111, exp_crc: 32'h9BE3_E0A3, chk_crc: 1'b1, exp_cnt: 4, exp_ok: 1'b0};

        rst_n = 1'b0; sel = 1;
        tb_valid = 1'b0; tb_sof = 1'b0; tb_eop = 1'b0; tb_abort = 1'b0;
        tb_data = '0; tb_keep = '0;

        // Reset state of every instance.
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check("rst_crc", 64'(mon_crc), 64'd0);
            check("rst_valid", {63'd0, mon_valid}, 64'd0);
            check("rst_ok", {63'd0, mon_ok}, 64'd0);
            check("rst_cnt", 64'(mon_cnt), 64'd0);
            check("rst_err", {63'd0, mon_err}, 64'd0);
            check("rst_ready", {63'd0, mon_ready}, 64'd1);
        end
        sel = 1;
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Known-answer vectors on the 32-bit instance.
        foreach (vecs[v]) begin
            pre_v = n_valid;
            for (int b = 0; b < vecs[v].nbeats; b++) begin
                beat(b == 0, b == vecs[v].nbeats - 1, 64'(vecs[v].d[b]),
                     (b == vecs[v].nbeats - 1) ? {4'h0, vecs[v].last_keep} : 8'h0F, w);
            end
            check("vec_valid_next_cycle", {63'd0, mon_valid}, 64'd1);
            check("vec_valid_count", 64'(n_valid), 64'(pre_v + 1));
            if (vecs[v].chk_crc) check("vec_crc", 64'(mon_crc), 64'(vecs[v].exp_crc));
            check("vec_cnt", 64'(mon_cnt), 64'(vecs[v].exp_cnt));
            check("vec_ok", {63'd0, mon_ok}, {63'd0, vecs[v].exp_ok});
        end

        // Outputs hold after DONE, and abort during DONE changes nothing.
        held = mon_crc;
        tb_abort = 1'b1;
        step();
        tb_abort = 1'b0;
        step();
        check("hold_crc", 64'(mon_crc), 64'(held));
        check("hold_cnt", 64'(mon_cnt), 64'd4);

        // Abort on the middle beat: beat refused, no pulse, no error.
        pre_v = n_valid; pre_e = n_err;
        beat(1'b1, 1'b0, 64'h3433_3231, 8'h0F, w);
        tb_valid = 1'b1; tb_abort = 1'b1; tb_data = 64'h3837_3635; tb_keep = 8'h0F;
        step();
        tb_valid = 1'b0; tb_abort = 1'b0;
        repeat (3) step();
        check("abort_no_valid", 64'(n_valid), 64'(pre_v));
        check("abort_no_err", 64'(n_err), 64'(pre_e));
        send_frame(str_bytes("123456789"), 4, 0, 65535);
        check("after_abort_crc", 64'(mon_crc), 64'hCBF4_3926);
        step();

        // Beat without sof in IDLE.
        pre_v = n_valid;
        beat(1'b0, 1'b0, 64'h1122_3344, 8'h0F, w);
        check("err_no_sof", {63'd0, mon_err}, 64'd1);
        step();
        check("err_pulse_one_cycle", {63'd0, mon_err}, 64'd0);
        check("no_sof_no_valid", 64'(n_valid), 64'(pre_v));

        // sof while in ACC restarts the frame.
        pre_v = n_valid;
        beat(1'b1, 1'b0, 64'h6463_6261, 8'h0F, w);
        beat(1'b1, 1'b0, 64'h3433_3231, 8'h0F, w);
        check("err_sof_in_acc", {63'd0, mon_err}, 64'd1);
        beat(1'b0, 1'b0, 64'h3837_3635, 8'h0F, w);
        check("err_cleared", {63'd0, mon_err}, 64'd0);
        beat(1'b0, 1'b1, 64'h0000_0039, 8'h01, w);
        check("restart_valid_count", 64'(n_valid), 64'(pre_v + 1));
        check("restart_crc", 64'(mon_crc), 64'hCBF4_3926);
        check("restart_cnt", 64'(mon_cnt), 64'd9);

        // Non-contiguous keep on eop: only byte 0 used.
        q = '{8'h31};
        beat(1'b1, 1'b1, 64'h3433_3231, 8'b0101, w);
        check("gap_keep_valid", {63'd0, mon_valid}, 64'd1);
        check("gap_keep_err", {63'd0, mon_err}, 64'd1);
        check("gap_keep_cnt", 64'(mon_cnt), 64'd1);
        check("gap_keep_crc", 64'(mon_crc), 64'(ref_crc(q)));

        // All-zero keep on eop: frame completes with nothing added.
        beat(1'b1, 1'b0, 64'h3433_3231, 8'h0F, w);
        beat(1'b0, 1'b1, 64'hDEAD_BEEF, 8'h00, w);
        check("zero_keep_valid", {63'd0, mon_valid}, 64'd1);
        check("zero_keep_err", {63'd0, mon_err}, 64'd1);
        check("zero_keep_cnt", 64'(mon_cnt), 64'd4);
        check("zero_keep_crc", 64'(mon_crc), 64'h9BE3_E0A3);

        // Reset in the middle of a frame.
        step();
        beat(1'b1, 1'b0, 64'h3433_3231, 8'h0F, w);
        rst_n = 1'b0;
        #1;
        check("midrst_crc", 64'(mon_crc), 64'd0);
        check("midrst_cnt", 64'(mon_cnt), 64'd0);
        check("midrst_ok", {63'd0, mon_ok}, 64'd0);
        check("midrst_valid", {63'd0, mon_valid}, 64'd0);
        check("midrst_err", {63'd0, mon_err}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pre_v = n_valid;
        repeat (3) step();
        check("midrst_no_valid", 64'(n_valid), 64'(pre_v));

        // Random frames: sweep every last-beat keep length, back to back.
        foreach (vecs[v]) begin end
        for (int si = 0; si < 3; si++) begin
            sel = (si == 0) ? 0 : ((si == 1) ? 2 : 1);
            nb  = (sel == 0) ? 1 : ((sel == 1) ? 4 : 8);
            for (int n = 1; n <= nb; n++) begin
                for (int r = 0; r < 2; r++) begin
                    len = $urandom_range(0, 3) * nb + n;
                    if (len >= 5 && $urandom_range(0, 1) == 1) begin
                        q   = rand_bytes(len - 4);
                        fcs = ref_crc(q);
                        q.push_back(fcs[7:0]);   q.push_back(fcs[15:8]);
                        q.push_back(fcs[23:16]); q.push_back(fcs[31:24]);
                    end else begin
                        q = rand_bytes(len);
                    end
                    send_frame(q, nb, (n == 1 && r == 0) ? 0 : 1,
                               (sel == 0) ? 63 : 65535);
                end
            end
            step();
        end

        // Byte counter saturation on the 8-bit instance (6-bit counter).
        sel = 0;
        send_frame(rand_bytes(70), 1, 0, 63);
        check("sat_cnt", 64'(mon_cnt), 64'd63);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mac_crc32_stream.md
Name: mac_crc32_stream

Overview:
- Parametrised-width Ethernet CRC-32 engine for the MAC TX FCS generator and the RX FCS checker.
- Accepts DATA_W-bit beats with byte-keep and frames them with sof/eop.
- Returns the final complemented FCS, a residue-based good/bad flag and a byte count for each frame.
- Successor of the byte-wide CRC unit: adds multi-byte beats, partial last beats, framing FSM, abort, and a residue check.

Parameters:
- DATA_W, 32, beat width in bits; legal values 8, 16, 32, 64; NB = DATA_W/8 bytes per beat.
- CNT_W, 16, width of the frame byte counter; saturates at all-ones.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  async active-low reset.
- valid_i  in  1  beat valid.
- ready_o  out  1  beat accepted when valid_i & ready_o.
- sof_i  in  1  first beat of frame; qualified by valid_i.
- eop_i  in  1  last beat of frame; qualified by valid_i.
- abort_i  in  1  drop current frame; not qualified by valid_i.
- data_i  in  DATA_W  beat data; byte k at [8k+7:8k]; byte 0 is first on the wire; bits LSB-first.
- keep_i  in  NB  byte valid mask; used only on eop beats; must be contiguous from bit 0.
- crc_o  out  32  final FCS = ~register; crc_o[7:0] is transmitted first.
- crc_valid_o  out  1  one-cycle pulse: crc_o, crc_ok_o and byte_cnt_o are valid.
- crc_ok_o  out  1  residue match; meaningful when crc_valid_o.
- byte_cnt_o  out  CNT_W  bytes of the completed frame.
- err_o  out  1  one-cycle protocol error pulse.

Behaviour:
- Reset values: crc_o=0, crc_valid_o=0, crc_ok_o=0, byte_cnt_o=0, err_o=0. Internal CRC register = 32'hFFFF_FFFF, FSM in IDLE.
- Reset asserted mid-frame discards the frame; no crc_valid_o is produced.
- CRC arithmetic:
  - Reflected polynomial 32'hEDB88320, init 32'hFFFF_FFFF, final XOR 32'hFFFF_FFFF.
  - Bytes are applied in order 0..NB-1 within a beat, as a single-cycle unrolled combinational update.
  - On the eop beat only the bytes with keep set are applied; on other beats all NB bytes are applied.
- FSM states: IDLE, ACC, DONE. ready_o = 1 in IDLE and ACC, 0 in DONE.
- IDLE:
  - Accepted beat with sof_i: the register is re-initialised, the beat is applied, byte count = bytes applied.
  - Go to DONE if eop_i is also set (single-beat frame), else go to ACC.
  - Accepted beat without sof_i is dropped, err_o pulses, state stays IDLE.
- ACC:
  - Accepted beat updates the register and adds its bytes to the count.
  - Accepted beat with eop_i: go to DONE.
  - Accepted beat with sof_i (missing eop): err_o pulses, the old frame is discarded without crc_valid_o, and the new frame restarts from init using this beat.
- DONE (exactly 1 cycle):
  - crc_valid_o=1; crc_o = ~register; byte_cnt_o = count.
  - crc_ok_o = (register == 32'hDEBB20E3), equivalently crc_o == 32'h2144DF1C.
  - Next state IDLE.
- Latency: crc_valid_o is asserted the cycle after the eop beat is accepted. Maximum throughput is one beat per cycle within a frame, plus one idle cycle between frames.
- crc_o, crc_ok_o and byte_cnt_o hold their values until the next DONE.
- abort_i:
  - In ACC or IDLE it forces IDLE, overrides any beat in the same cycle (the beat is not accepted), and produces no crc_valid_o and no err_o.
  - In DONE it is ignored; the pulse still occurs.
- keep_i on an eop beat:
  - All-zero: err_o pulses; the frame completes normally with zero bytes added.
  - Non-contiguous: err_o pulses; only the bytes below the first zero bit are used.
- Byte counter saturates at 2^CNT_W-1 and does not wrap.

Test Plan:
- DATA_W=32, no abort.
  - Stimulus: beats 32'h34333231, 32'h38373635, then 32'h00000039 with keep=4'b0001, eop ("123456789").
  - Required: crc_valid_o one cycle after the eop beat; crc_o=32'hCBF43926, byte_cnt_o=9, crc_ok_o=0.
- Same 9 bytes followed by FCS bytes 26 39 F4 CB (beat3 = 32'hF4392639 keep 1111, beat4 = 32'h000000CB keep 0001 eop).
  - Required: crc_o=32'h2144DF1C, crc_ok_o=1, byte_cnt_o=13.
  - Repeat with one data bit flipped: crc_ok_o=0.
- DATA_W=8 and DATA_W=64, sweep of all NB keep values on the last beat with random payloads.
  - Required: crc_o matches a byte-serial reference model; back-to-back frames show ready_o low exactly in the DONE cycle.
- Single-beat frame: sof&eop with keep=4'b1111 on 32'h34333231 ("1234").
  - Required: crc_o=32'h9BE3E0A3, byte_cnt_o=4.
- abort_i asserted on the middle beat of a 3-beat frame, then a clean "123456789" frame.
  - Required: no crc_valid_o for the aborted frame; the next frame gives 32'hCBF43926.
  - Also: reset_i low mid-frame clears all outputs to 0.
- Protocol errors, each giving a one-cycle err_o pulse:
  - beat without sof in IDLE;
  - sof in ACC, after which the restarted frame gives the correct CRC;
  - keep=4'b0101 on eop, after which only byte 0 is counted.
